phy_rx_lane_demux: RTL and testbench
====================================

// Module: phy_rx_lane_demux
// PURPOSE
//   Parametrised 1-to-NUM_LANES time-division byte demultiplexer for the PHY RX path.
//   Beats arriving one per clk_f cycle are distributed round-robin into lane slots.
//   Each completed group of NUM_LANES beats is presented in parallel, one cycle after
//   its last beat, with a per-lane valid mask and a one-cycle group strobe.
//   Generalises the fixed 4-lane demux: any lane count, any width, an explicit lane
//   realignment input, a selectable invalid-beat policy, and partial-group drop reporting.
// PARAMETERS
//   DATA_W        8  width of one beat/lane in bits (>=1)
//   NUM_LANES     4  lanes per group (>=1, need not be a power of 2)
//   HOLD_INVALID  0  0: an invalid beat loads 0 into its lane; 1: the lane keeps its last data_out value
// PORTS
//   clk_f         in   1                    single clock, all logic on posedge
//   reset         in   1                    synchronous, active-high
//   data_in       in   DATA_W               serial beat
//   valid_in      in   1                    beat qualifier; the slot is consumed even when 0
//   align_in      in   1                    current beat is lane 0 of a new group
//   data_out      out  NUM_LANES*DATA_W     lane k at bits [k*DATA_W +: DATA_W] (lane 0 in the LSBs)
//   valid_out     out  NUM_LANES            bit k = valid_in captured for lane k
//   group_strobe  out  1                    1-cycle pulse: data_out/valid_out updated this cycle
//   partial_drop  out  1                    1-cycle pulse: an incomplete group was discarded
// BEHAVIOUR
//   - Reset (sampled at posedge): data_out=0, valid_out=0, group_strobe=0, partial_drop=0.
//     lane_idx=0; shadow data and shadow valids cleared. A partial group in flight is discarded.
//     partial_drop is not raised for a reset discard.
//   - lane_idx is a counter of width clog2(NUM_LANES), minimum 1 bit. It advances on every
//     non-reset cycle, valid or not, and wraps NUM_LANES-1 -> 0.
//   - Effective slot per cycle: slot = align_in ? 0 : lane_idx.
//     - shadow[slot] <= valid_in ? data_in : (HOLD_INVALID ? data_out lane slot : 0).
//     - shadow_v[slot] <= valid_in.
//   - align_in=1:
//     - Next lane_idx is 1, or 0 when NUM_LANES==1.
//     - If lane_idx!=0 that cycle, the partial group is dropped: shadow_v cleared except
//       slot 0, and partial_drop=1 next cycle.
//     - If lane_idx==0, align_in is a no-op and partial_drop stays 0.
//   - Group completion: slot==NUM_LANES-1 at cycle t, with align_in=0 or NUM_LANES==1.
//     - At t+1: data_out/valid_out = full group including the beat from t; group_strobe=1.
//     - Latency is one cycle from the last beat. Outputs are registered.
//   - Between strobes, data_out and valid_out hold. group_strobe=0 on all other cycles.
//   - An all-invalid group still completes: group_strobe=1 with valid_out=0.
//   - NUM_LANES==1: every cycle completes a group. group_strobe=1 every cycle after reset
//     deasserts. partial_drop is never raised.
//   - align_in together with group completion (NUM_LANES==1 only): completion wins, no drop.
//   - align_in and reset both high: reset wins.
//   - No backpressure; the consumer samples on group_strobe.
// TESTING (NUM_LANES=4, DATA_W=8, HOLD_INVALID=0 unless stated)
//   1. Reset, then DD,EE,CC,BB all valid on 4 cycles
//      -> next cycle data_out=32'hBBCCEEDD, valid_out=4'hF, group_strobe=1 for exactly 1 cycle.
//   2. 99,AA,88,88 with valid 1,1,1,0
//      -> data_out=32'h0088AA99, valid_out=4'b0111.
//      Repeat with HOLD_INVALID=1 after group BBCCEEDD -> data_out=32'hBB88AA99.
//   3. DD,EE, then align_in=1 with CC, then BB,99,AA
//      -> partial_drop=1 one cycle after CC; next strobe data_out=32'hAA99BBCC, valid_out=4'hF.
//   4. align_in=1 exactly on a lane-0 beat
//      -> partial_drop stays 0; group timing unchanged.
//   5. reset=1 after 2 beats of a group, then 4 fresh beats 11,22,33,44
//      -> no strobe for the partial group; outputs 0 during reset; then data_out=32'h44332211.
//   6. NUM_LANES=3, DATA_W=16, beats 1111..6666
//      -> strobes carry 48'h333322221111, then 48'h666655554444, exactly 3 cycles apart.

Source files
------------

// File: rtl/phy_rx_lane_demux.sv
// phy_rx_lane_demux
// Round-robin 1-to-NUM_LANES byte demultiplexer for the PHY RX path. Serial
// beats fill lane slots in a shadow buffer. One cycle after the last beat of a
// group, the whole group is presented in parallel and group_strobe pulses.
// align_in restarts a group at lane 0. If a group was already in progress, its
// beats are discarded and partial_drop pulses.

module phy_rx_lane_demux #(
    parameter int DATA_W       = 8,
    parameter int NUM_LANES    = 4,
    parameter bit HOLD_INVALID = 1'b0
) (
    input  logic                        clk_f,
    input  logic                        reset,
    input  logic [DATA_W-1:0]           data_in,
    input  logic                        valid_in,
    input  logic                        align_in,
    output logic [NUM_LANES*DATA_W-1:0] data_out,
    output logic [NUM_LANES-1:0]        valid_out,
    output logic                        group_strobe,
    output logic                        partial_drop
);

    localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_LANES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    // After a realignment the aligning beat already occupies lane 0. The
    // single-lane case therefore wraps straight back to 0.
    localparam logic [IDX_W-1:0] ALIGN_NEXT = (NUM_LANES > 1) ? IDX_ONE : '0;

    logic [IDX_W-1:0]     lane_idx;
    logic [IDX_W-1:0]     lane_idx_nxt;
    logic [IDX_W-1:0]     slot;
    logic [DATA_W-1:0]    beat_data;
    logic [DATA_W-1:0]    shadow     [NUM_LANES];
    logic [DATA_W-1:0]    shadow_nxt [NUM_LANES];
    logic [DATA_W-1:0]    out_lane   [NUM_LANES];
    logic [NUM_LANES-1:0] shadow_v;
    logic [NUM_LANES-1:0] shadow_v_nxt;
    logic                 complete;
    logic                 drop;

    // Slot selection, beat value, group completion/drop detection and next shadow contents.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path first. A missed path would otherwise infer a latch.
        slot         = align_in ? '0 : lane_idx;
        complete     = (slot == LAST_IDX) && (!align_in || (NUM_LANES == 1));
        drop         = align_in && (lane_idx != '0);
        beat_data    = '0;
        lane_idx_nxt = '0;
        shadow_nxt   = shadow;
        shadow_v_nxt = drop ? '0 : shadow_v;

        if (valid_in) begin
            beat_data = data_in;
        end else if (HOLD_INVALID) begin
            beat_data = out_lane[slot];
        end

        if (align_in) begin
            lane_idx_nxt = ALIGN_NEXT;
        end else if (lane_idx != LAST_IDX) begin
            lane_idx_nxt = lane_idx + IDX_ONE;
        end

        shadow_nxt[slot]   = beat_data;
        shadow_v_nxt[slot] = valid_in;
    end

    // Lane counter, shadow buffer and registered group outputs.
    always_ff @(posedge clk_f) begin
        // NOTE: sequential state uses non-blocking assignments only. All
        // registers then update together from values sampled before the edge.
        if (reset) begin
            lane_idx     <= '0;
            shadow_v     <= '0;
            valid_out    <= '0;
            group_strobe <= 1'b0;
            partial_drop <= 1'b0;
            // NOTE: the shadow buffer is small and is cleared on reset. A
            // discarded partial group therefore leaves no stale data behind.
            for (int k = 0; k < NUM_LANES; k++) begin
                shadow[k]   <= '0;
                out_lane[k] <= '0;
            end
        end else begin
            lane_idx     <= lane_idx_nxt;
            shadow       <= shadow_nxt;
            shadow_v     <= shadow_v_nxt;
            group_strobe <= complete;
            partial_drop <= drop;
            if (complete) begin
                out_lane  <= shadow_nxt;
                valid_out <= shadow_v_nxt;
            end
        end
    end

    // Lane k occupies bits [k*DATA_W +: DATA_W]. Lane 0 sits in the LSBs.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_pack
        assign data_out[g*DATA_W +: DATA_W] = out_lane[g];
    end

endmodule

// File: tb/tb_phy_rx_lane_demux.sv
// tb_phy_rx_lane_demux
// Directed bench for phy_rx_lane_demux. Three 4-lane/8-bit-family instances
// share one stimulus stream: a (drop invalid beats), b (hold on invalid) and
// d (single lane). A separate 3-lane/16-bit instance c gets its own stream.
// Expected values are hand-computed constants.

module tb_phy_rx_lane_demux;

    logic clk_f = 1'b0;
    always #5 clk_f = ~clk_f;

    int tests_run = 0;
    int tests_failed = 0;

    // Shared stimulus for the a, b and d instances.
    logic        reset;
    logic [7:0]  data_in;
    logic        valid_in;
    logic        align_in;

    // Stimulus for the c instance.
    logic        c_reset;
    logic [15:0] c_data_in;
    logic        c_valid_in;
    logic        c_align_in;

    logic [31:0] a_data_out;
    logic [3:0]  a_valid_out;
    logic        a_strobe;
    logic        a_drop;
    logic [31:0] b_data_out;
    logic [3:0]  b_valid_out;
    logic        b_strobe;
    logic        b_drop;
    logic [7:0]  d_data_out;
    logic [0:0]  d_valid_out;
    logic        d_strobe;
    logic        d_drop;
    logic [47:0] c_data_out;
    logic [2:0]  c_valid_out;
    logic        c_strobe;
    logic        c_drop;

    phy_rx_lane_demux #(.DATA_W(8), .NUM_LANES(4), .HOLD_INVALID(1'b0)) u_a (
        .clk_f(clk_f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .align_in(align_in), .data_out(a_data_out), .valid_out(a_valid_out),
        .group_strobe(a_strobe), .partial_drop(a_drop)
    );

    phy_rx_lane_demux #(.DATA_W(8), .NUM_LANES(4), .HOLD_INVALID(1'b1)) u_b (
        .clk_f(clk_f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .align_in(align_in), .data_out(b_data_out), .valid_out(b_valid_out),
        .group_strobe(b_strobe), .partial_drop(b_drop)
    );

    phy_rx_lane_demux #(.DATA_W(8), .NUM_LANES(1), .HOLD_INVALID(1'b0)) u_d (
        .clk_f(clk_f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .align_in(align_in), .data_out(d_data_out), .valid_out(d_valid_out),
        .group_strobe(d_strobe), .partial_drop(d_drop)
    );

    phy_rx_lane_demux #(.DATA_W(16), .NUM_LANES(3), .HOLD_INVALID(1'b0)) u_c (
        .clk_f(clk_f), .reset(c_reset), .data_in(c_data_in), .valid_in(c_valid_in),
        .align_in(c_align_in), .data_out(c_data_out), .valid_out(c_valid_out),
        .group_strobe(c_strobe), .partial_drop(c_drop)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Outputs are sampled 1 time unit after the edge that consumed the beat.
    task automatic tick();
        @(posedge clk_f);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic v, input logic al);
        data_in  = d;
        valid_in = v;
        align_in = al;
        tick();
    endtask

    task automatic cbeat(input logic [15:0] d, input logic v, input logic al);
        c_data_in  = d;
        c_valid_in = v;
        c_align_in = al;
        tick();
    endtask

    initial begin
        reset      = 1'b1;
        data_in    = '0;
        valid_in   = 1'b0;
        align_in   = 1'b0;
        c_reset    = 1'b1;
        c_data_in  = '0;
        c_valid_in = 1'b0;
        c_align_in = 1'b0;

        // Reset state.
        tick();
        tick();
        check("rst_a_data",   a_data_out, 0);
        check("rst_a_valid",  a_valid_out, 0);
        check("rst_a_strobe", a_strobe, 0);
        check("rst_a_drop",   a_drop, 0);
        check("rst_d_strobe", d_strobe, 0);
        check("rst_c_data",   c_data_out, 0);

        // Test 1: DD,EE,CC,BB all valid.
        reset = 1'b0;
        beat(8'hDD, 1'b1, 1'b0);
        check("n1_d_strobe", d_strobe, 1);
        check("n1_d_data",   d_data_out, 8'hDD);
        beat(8'hEE, 1'b1, 1'b0);
        beat(8'hCC, 1'b1, 1'b0);
        check("t1_no_early_strobe", a_strobe, 0);
        beat(8'hBB, 1'b1, 1'b0);
        check("t1_data",   a_data_out, 32'hBBCCEEDD);
        check("t1_valid",  a_valid_out, 4'hF);
        check("t1_strobe", a_strobe, 1);
        check("t1_b_data", b_data_out, 32'hBBCCEEDD);

        // Test 2: 99,AA,88,88 with the last beat invalid.
        beat(8'h99, 1'b1, 1'b0);
        check("t2_strobe_one_cycle", a_strobe, 0);
        check("t2_hold_data", a_data_out, 32'hBBCCEEDD);
        beat(8'hAA, 1'b1, 1'b0);
        beat(8'h88, 1'b1, 1'b0);
        beat(8'h88, 1'b0, 1'b0);
        check("t2_data",     a_data_out, 32'h0088AA99);
        check("t2_valid",    a_valid_out, 4'b0111);
        check("t2_strobe",   a_strobe, 1);
        check("t2_hold_inv", b_data_out, 32'hBB88AA99);
        check("n1_inv_data",  d_data_out, 8'h00);
        check("n1_inv_valid", d_valid_out, 1'b0);

        // Test 3: DD,EE, then align with CC, then BB,99,AA.
        beat(8'hDD, 1'b1, 1'b0);
        beat(8'hEE, 1'b1, 1'b0);
        beat(8'hCC, 1'b1, 1'b1);
        check("t3_drop",   a_drop, 1);
        check("t3_no_strobe", a_strobe, 0);
        check("n1_no_drop", d_drop, 0);
        check("n1_align_strobe", d_strobe, 1);
        beat(8'hBB, 1'b1, 1'b0);
        check("t3_drop_one_cycle", a_drop, 0);
        beat(8'h99, 1'b1, 1'b0);
        check("t3_no_early_strobe", a_strobe, 0);
        beat(8'hAA, 1'b1, 1'b0);
        check("t3_data",   a_data_out, 32'hAA99BBCC);
        check("t3_valid",  a_valid_out, 4'hF);
        check("t3_strobe", a_strobe, 1);

        // Test 4: align exactly on a lane-0 beat.
        beat(8'h11, 1'b1, 1'b1);
        check("t4_no_drop", a_drop, 0);
        beat(8'h22, 1'b1, 1'b0);
        beat(8'h33, 1'b1, 1'b0);
        check("t4_no_early_strobe", a_strobe, 0);
        beat(8'h44, 1'b1, 1'b0);
        check("t4_data",   a_data_out, 32'h44332211);
        check("t4_strobe", a_strobe, 1);
        check("t4_no_drop_end", a_drop, 0);

        // All-invalid group still completes.
        beat(8'h5A, 1'b0, 1'b0);
        beat(8'h5A, 1'b0, 1'b0);
        beat(8'h5A, 1'b0, 1'b0);
        beat(8'h5A, 1'b0, 1'b0);
        check("inv_strobe", a_strobe, 1);
        check("inv_valid",  a_valid_out, 4'h0);
        check("inv_data",   a_data_out, 32'h0);

        // Test 5: reset after 2 beats, with align also high during reset.
        beat(8'h55, 1'b1, 1'b0);
        beat(8'h66, 1'b1, 1'b0);
        reset = 1'b1;
        beat(8'h77, 1'b1, 1'b1);
        check("t5_rst_data",   a_data_out, 0);
        check("t5_rst_strobe", a_strobe, 0);
        check("t5_rst_drop",   a_drop, 0);
        reset = 1'b0;
        beat(8'h11, 1'b1, 1'b0);
        check("t5_no_drop", a_drop, 0);
        beat(8'h22, 1'b1, 1'b0);
        beat(8'h33, 1'b1, 1'b0);
        check("t5_no_partial_strobe", a_strobe, 0);
        beat(8'h44, 1'b1, 1'b0);
        check("t5_data",   a_data_out, 32'h44332211);
        check("t5_strobe", a_strobe, 1);
        check("t5_valid",  a_valid_out, 4'hF);

        // Test 6: NUM_LANES=3, DATA_W=16.
        c_reset = 1'b0;
        cbeat(16'h1111, 1'b1, 1'b0);
        cbeat(16'h2222, 1'b1, 1'b0);
        check("t6_no_early_strobe", c_strobe, 0);
        cbeat(16'h3333, 1'b1, 1'b0);
        check("t6_g1_data",   c_data_out, 48'h333322221111);
        check("t6_g1_strobe", c_strobe, 1);
        cbeat(16'h4444, 1'b1, 1'b0);
        check("t6_gap1", c_strobe, 0);
        cbeat(16'h5555, 1'b1, 1'b0);
        check("t6_gap2", c_strobe, 0);
        check("t6_hold", c_data_out, 48'h333322221111);
        cbeat(16'h6666, 1'b1, 1'b0);
        check("t6_g2_data",   c_data_out, 48'h666655554444);
        check("t6_g2_strobe", c_strobe, 1);
        check("t6_g2_valid",  c_valid_out, 3'b111);

        // 3-lane realignment mid-group.
        cbeat(16'h7777, 1'b1, 1'b0);
        cbeat(16'h8888, 1'b1, 1'b1);
        check("t6_drop", c_drop, 1);
        cbeat(16'h9999, 1'b1, 1'b0);
        cbeat(16'hAAAA, 1'b1, 1'b0);
        check("t6_realign_data",   c_data_out, 48'hAAAA99998888);
        check("t6_realign_strobe", c_strobe, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
